// File: rtl/alu4_arbiter.sv
// alu4_arbiter: shares one external alu4 among NREQ requesters, holding the operand for EVAL_CYC
// settle cycles before capturing the tagged result. Define ALU4_ARB_RR_EN for round-robin grants.
module alu4_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int EVAL_CYC = 1
) (
    input  logic                 i_clk_,
    input  logic                 i_rst_,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [14*NREQ-1:0]   req_data,
    output logic [13:0]          alu_in,
    input  logic [7:0]           alu_out,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [7:0]           resp_data,
    output logic [IDW-1:0]       resp_id,
    output logic                 busy
);

    localparam int PTRW = $clog2(NREQ);
    localparam int CNTW = (EVAL_CYC > 1) ? $clog2(EVAL_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [13:0]     aluIn_q, aluIn_d;
    logic [PTRW-1:0] idReg_q, idReg_d;
    logic [7:0]      respData_q, respData_d;
    logic [IDW-1:0]  respId_q, respId_d;
    logic            respValid_q, respValid_d;

    logic [PTRW-1:0] grantIdx;
    logic [13:0]     grantData;
    logic            anyValid;

    assign anyValid = |req_valid;

`ifdef ALU4_ARB_RR_EN
    logic [PTRW-1:0] ptr_q, ptr_d;

    // The winner is the valid requester with the smallest circular distance from ptr.
    always_comb begin
        int bestDist;
        int dist;
        grantIdx = '0;
        bestDist = NREQ;
        dist     = 0;
        for (int j = 0; j < NREQ; j++) begin
            if (j >= int'(ptr_q)) begin
                dist = j - int'(ptr_q);
            end else begin
                dist = j + NREQ - int'(ptr_q);
            end
            if (req_valid[j] && (dist < bestDist)) begin
                bestDist = dist;
                grantIdx = PTRW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == IDLE) && anyValid) begin
            if (grantIdx == PTRW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grantIdx + PTRW'(1);
            end
        end
    end

    always_ff @(posedge i_clk_ or posedge i_rst_) begin
        if (i_rst_) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Lowest index wins: scanning downward leaves the smallest valid index last.
    always_comb begin
        grantIdx = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                grantIdx = PTRW'(j);
            end
        end
    end
`endif

    always_comb begin
        grantData = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grantIdx == PTRW'(j)) begin
                grantData = req_data[j*14 +: 14];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        aluIn_d     = aluIn_q;
        idReg_d     = idReg_q;
        respData_d  = respData_q;
        respId_d    = respId_q;
        respValid_d = respValid_q;
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    aluIn_d = grantData;
                    idReg_d = grantIdx;
                    cnt_d   = CNTW'(EVAL_CYC - 1);
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (cnt_q == '0) begin
                    respData_d  = alu_out;
                    respId_d    = IDW'(idReg_q);
                    respValid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    respValid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                respValid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk_ or posedge i_rst_) begin
        if (i_rst_) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            aluIn_q     <= '0;
            idReg_q     <= '0;
            respData_q  <= '0;
            respId_q    <= '0;
            respValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            aluIn_q     <= aluIn_d;
            idReg_q     <= idReg_d;
            respData_q  <= respData_d;
            respId_q    <= respId_d;
            respValid_q <= respValid_d;
        end
    end

    // Grant is masked during reset so nothing is accepted while the registers are held.
    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && anyValid && !i_rst_) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    assign alu_in     = aluIn_q;
    assign resp_valid = respValid_q;
    assign resp_data  = respData_q;
    assign resp_id    = respId_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu4_arbiter.md
# alu4_arbiter

Sequencer/arbiter sharing a single combinational alu4 netlist (14 inputs i_0_..i_13_, 8 outputs ori0..ori7) among NREQ requesters. It grants one requester at a time and drives the ALU operand register. It holds the operand stable for a programmable number of settle cycles, then captures the result and returns it tagged with the requester index. The ALU sits outside this block on alu_in/alu_out, so the synthesized netlist can be swapped or stubbed.

## Interface
- NREQ, 4, number of requesters (2..16)
- IDW, 2, width of resp_id; must be ≥ clog2(NREQ)
- EVAL_CYC, 1, cycles alu_in is held stable before capture (≥ 1; multicycle path through ALU)
- i_clk_  in  1  clock, rising edge
- i_rst_  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot grant/accept; at most one bit high
- req_data  in  14*NREQ  operand of requester k in bits [14k+13:14k]; bit j maps to ALU input i_j_
- alu_in  out  14  registered operand to ALU (bit j → i_j_)
- alu_out  in  8  ALU result (bit n ← orin)
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  8  captured result
- resp_id  out  IDW  index of requester that owns resp_data
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EVAL, RESP.
- IDLE: arbitration winner g is computed combinationally from req_valid and the pointer ptr. req_ready[g]=1 only if some req_valid bit is set. On req_valid[g]&req_ready[g]: alu_in←req_data slice g, id_reg←g, cnt←EVAL_CYC-1, state→EVAL.
- EVAL: req_ready=0. If cnt==0: resp_data←alu_out, resp_id←id_reg, resp_valid←1, state→RESP. Else cnt←cnt-1.
- RESP: resp_valid=1, req_ready=0. On resp_ready: resp_valid←0, state→IDLE. resp_data and resp_id stay stable while resp_valid is high.
- alu_in holds its last operand after response; it is not cleared.
- req_valid changes outside IDLE are ignored. An ungranted requester keeps waiting; no request is dropped.
- ptr is a clog2(NREQ)-bit register, updated only on accept.
- Reset (any state, asynchronous): state=IDLE, ptr=0, cnt=0, alu_in=0, resp_data=0, resp_id=0, resp_valid=0, busy=0. req_ready is forced to 0 while i_rst_ is high. An in-flight operation is discarded with no response.

## Timing
- Accept in cycle 0 → alu_in valid from cycle 1 → capture at the end of cycle EVAL_CYC → resp_valid high from cycle EVAL_CYC+1.
- The earliest next accept is the cycle after the resp_valid&resp_ready handshake. Peak throughput is one op per EVAL_CYC+2 cycles.
- The accept cycle is not counted as a settle cycle.
- resp_ready may be held high permanently. RESP then lasts exactly 1 cycle.
- req_ready is combinational from req_valid, ptr and state. There is no combinational path from resp_ready to req_ready, because RESP→IDLE is registered.

## Configuration
- ALU4_ARB_RR_EN defined: round-robin.
  - Search starts at ptr and wraps modulo NREQ.
  - On accept of g, ptr←(g+1) mod NREQ.
  - Wrap example, NREQ=4: ptr=3 with req_valid=4'b1001 grants 3, then ptr=0.
- ALU4_ARB_RR_EN undefined: fixed priority, lowest index wins. ptr stays 0 and is unused. Requester 0 can starve others; this is accepted behaviour.

## Test plan
- Single op, default parameters: req_valid=4'b0100, slice 2=14'h1A5B in cycle 0. Bench ALU model drives alu_out=8'hC3. Expected: req_ready=4'b0100 in cycle 0, alu_in=14'h1A5B from cycle 1, resp_valid=1, resp_data=8'hC3, resp_id=2 in cycle 2, busy=1 in cycles 1–2.
- Back-pressure: as above with resp_ready=0 for 5 cycles. Expected: resp_valid/resp_data/resp_id stable, req_ready=0 throughout. Release resp_ready → IDLE next cycle, a new accept is possible that cycle.
- Arbitration with all requesters active, req_valid=4'b1111 continuously, resp_ready=1.
  - With ALU4_ARB_RR_EN: grant order 0,1,2,3,0, accepts every 3 cycles.
  - Without the macro: grant 0 every time.
- EVAL_CYC=4, ALU model changes alu_out each cycle. Expected: resp_data equals the alu_out value present in cycle 4 after accept, and resp_valid rises in cycle 5.
- Reset mid-operation: assert i_rst_ in an EVAL cycle. Expected: immediately resp_valid=0, busy=0, alu_in=0, req_ready=0. After deassert with req_valid=4'b0001, the grant goes to 0 (ptr reset) and no stale response appears.
- Idle check: req_valid=0 for 10 cycles. Expected: req_ready=0, busy=0, alu_in unchanged.
